// File: rtl/vout_pi_pwm_if.sv
// Sample/strobe inputs and duty/PWM/status outputs of the Vout PI + PWM stage.
// The master side drives measurements and strobes; the slave side is the compensator.
interface vout_pi_pwm_if #(
  parameter int W      = 13,
  parameter int DUTY_W = 10
);
  logic [W-1:0]      Vout;
  logic [W-1:0]      Iout;
  logic [W-1:0]      Temp;
  logic              SAMPLE_STB;
  logic              CLR_FAULT;
  logic              PWM_OUT;
  logic [DUTY_W-1:0] DUTY;
  logic              DUTY_VALID;
  logic              PERIOD_START;
  logic              FAULT;
  logic              OVERRUN;

  modport master (
    output Vout, Iout, Temp, SAMPLE_STB, CLR_FAULT,
    input  PWM_OUT, DUTY, DUTY_VALID, PERIOD_START, FAULT, OVERRUN
  );

  modport slave (
    input  Vout, Iout, Temp, SAMPLE_STB, CLR_FAULT,
    output PWM_OUT, DUTY, DUTY_VALID, PERIOD_START, FAULT, OVERRUN
  );
endinterface

// File: rtl/vout_pi_pwm.sv
// PI compensator with anti-windup feeding a free-running PWM gate driver,
// with latched over-current/over-temperature fault and ADC pacing pulse.
//
// state  | meaning
// IDLE   | wait for SAMPLE_STB, capture Vout/Iout/Temp
// ERR    | compute error e = VREF - Vout
// PI     | fault check, integrate e with clamp (anti-windup)
// SAT    | u = P + I, clamp to duty range
// LOAD   | publish DUTY (0 while faulted), pulse DUTY_VALID
module vout_pi_pwm #(
  parameter int W          = 13,
  parameter int VREF       = 4096,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 6,
  parameter int DUTY_W     = 10,
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_MIN   = 0,
  parameter int DUTY_MAX   = 900,
  parameter int ILIM       = 3800,
  parameter int TLIM       = 3500
) (
  input  logic          CLK20M,
  input  logic          RSTn,
  vout_pi_pwm_if.slave  bus
);

  localparam int IW = 24;
  localparam logic signed [W:0]    VREF_S   = (W+1)'(VREF);
  localparam logic signed [IW-1:0] INTEG_LO = IW'(DUTY_MIN * (2**KI_SHIFT));
  localparam logic signed [IW-1:0] INTEG_HI = IW'(DUTY_MAX * (2**KI_SHIFT));
  localparam logic signed [IW-1:0] U_LO     = IW'(DUTY_MIN);
  localparam logic signed [IW-1:0] U_HI     = IW'(DUTY_MAX);
  localparam logic [W-1:0]         ILIM_V   = W'(ILIM);
  localparam logic [W-1:0]         TLIM_V   = W'(TLIM);
  localparam logic [DUTY_W-1:0]    CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_PI, S_SAT, S_LOAD} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         vout_q, vout_d, iout_q, iout_d, temp_q, temp_d;
  logic signed [W:0]    e_q, e_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic [DUTY_W-1:0]    u_q, u_d, duty_q, duty_d;
  logic                 duty_valid_q, duty_valid_d;
  logic                 fault_q, fault_d, overrun_q, overrun_d;
  logic [DUTY_W-1:0]    cnt_q, cnt_d, duty_act_q, duty_act_d;
  logic                 pwm_q, pwm_d, pstart_q, pstart_d;

  logic signed [IW-1:0] e_ext, integ_sum, u_full;
  logic                 fault_set, fault_clr;

  // Set beats clear; clear is only honoured when the last captured sample is healthy.
  always_comb begin
    fault_set = (state_q == S_PI) && ((iout_q > ILIM_V) || (temp_q > TLIM_V));
    fault_clr = bus.CLR_FAULT && (iout_q <= ILIM_V) && (temp_q <= TLIM_V);
    fault_d   = fault_q;
    if (fault_set) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    vout_d       = vout_q;
    iout_d       = iout_q;
    temp_d       = temp_q;
    e_d          = e_q;
    integ_d      = integ_q;
    u_d          = u_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    overrun_d    = overrun_q;
    e_ext        = {{(IW-W-1){e_q[W]}}, e_q};
    integ_sum    = integ_q + e_ext;
    u_full       = (e_ext >>> KP_SHIFT) + (integ_q >>> KI_SHIFT);

    if (bus.SAMPLE_STB && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.SAMPLE_STB) begin
          vout_d  = bus.Vout;
          iout_d  = bus.Iout;
          temp_d  = bus.Temp;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e_d     = VREF_S - $signed({1'b0, vout_q});
        state_d = S_PI;
      end
      S_PI: begin
        // Storing the clamped sum is the anti-windup; a fault parks the integrator at 0.
        if (fault_d) begin
          integ_d = '0;
        end else if (integ_sum < INTEG_LO) begin
          integ_d = INTEG_LO;
        end else if (integ_sum > INTEG_HI) begin
          integ_d = INTEG_HI;
        end else begin
          integ_d = integ_sum;
        end
        state_d = S_SAT;
      end
      S_SAT: begin
        if (u_full < U_LO) begin
          u_d = DUTY_W'(U_LO);
        end else if (u_full > U_HI) begin
          u_d = DUTY_W'(U_HI);
        end else begin
          u_d = DUTY_W'(u_full);
        end
        state_d = S_LOAD;
      end
      S_LOAD: begin
        duty_d       = fault_q ? '0 : u_q;
        duty_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow duty is only sampled at wrap, so the gate never sees a mid-period change.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    duty_act_d = duty_act_q;
    pstart_d   = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      duty_act_d = duty_q;
      pstart_d   = 1'b1;
    end
    pwm_d = (cnt_q < duty_act_q) && !fault_q;
  end

  always_ff @(posedge CLK20M or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      vout_q       <= '0;
      iout_q       <= '0;
      temp_q       <= '0;
      e_q          <= '0;
      integ_q      <= '0;
      u_q          <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= '0;
      duty_act_q   <= '0;
      pwm_q        <= 1'b0;
      pstart_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vout_q       <= vout_d;
      iout_q       <= iout_d;
      temp_q       <= temp_d;
      e_q          <= e_d;
      integ_q      <= integ_d;
      u_q          <= u_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      fault_q      <= fault_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
      pstart_q     <= pstart_d;
    end
  end

  assign bus.PWM_OUT      = pwm_q;
  assign bus.DUTY         = duty_q;
  assign bus.DUTY_VALID   = duty_valid_q;
  assign bus.PERIOD_START = pstart_q;
  assign bus.FAULT        = fault_q;
  assign bus.OVERRUN      = overrun_q;

endmodule

// File: tb/tb_vout_pi_pwm.sv
// Self-checking bench for vout_pi_pwm: directed latency/PWM/fault/overrun cases
// plus randomized samples scored against an arithmetic PI reference model.
module tb_vout_pi_pwm;

  logic CLK20M = 1'b0;
  logic RSTn   = 1'b1;
  always #25 CLK20M = ~CLK20M;

  vout_pi_pwm_if #(.W(13), .DUTY_W(10)) vif ();

  vout_pi_pwm dut (
    .CLK20M (CLK20M),
    .RSTn   (RSTn),
    .bus    (vif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: integrator, fault latch, last captured Iout/Temp.
  int m_integ, m_fault, m_iout, m_temp;

  function automatic int model_sample(int v, int i, int t);
    int e, s, u;
    m_iout = i;
    m_temp = t;
    e = 4096 - v;
    if (i > 3800 || t > 3500) m_fault = 1;
    s = m_integ + e;
    if (s < 0) s = 0;
    if (s > 900 * 64) s = 900 * 64;
    m_integ = m_fault ? 0 : s;
    u = (e >>> 2) + (m_integ >>> 6);
    if (u < 0) u = 0;
    if (u > 900) u = 900;
    return m_fault ? 0 : u;
  endfunction

  function automatic void model_clear();
    if (m_iout <= 3800 && m_temp <= 3500) m_fault = 0;
  endfunction

  function automatic void model_reset();
    m_integ = 0; m_fault = 0; m_iout = 0; m_temp = 0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLK20M);
      #1;
    end
  endtask

  task automatic apply_reset();
    vif.Vout = '0; vif.Iout = '0; vif.Temp = '0;
    vif.SAMPLE_STB = 1'b0; vif.CLR_FAULT = 1'b0;
    RSTn = 1'b0;
    wait_cycles(3);
    RSTn = 1'b1;
    wait_cycles(2);
    model_reset();
  endtask

  // Returns just after the edge that samples the strobe (edge k).
  task automatic send(input int v, input int i, input int t);
    vif.Vout = 13'(v); vif.Iout = 13'(i); vif.Temp = 13'(t);
    vif.SAMPLE_STB = 1'b1;
    wait_cycles(1);
    vif.SAMPLE_STB = 1'b0;
  endtask

  task automatic do_sample(input int v, input int i, input int t,
                           output logic val3, output logic val4,
                           output logic [9:0] duty, output logic flt);
    send(v, i, t);
    wait_cycles(3);
    val3 = vif.DUTY_VALID;
    wait_cycles(1);
    val4 = vif.DUTY_VALID;
    duty = vif.DUTY;
    flt  = vif.FAULT;
    wait_cycles(1);
  endtask

  task automatic pulse_clear();
    vif.CLR_FAULT = 1'b1;
    wait_cycles(1);
    vif.CLR_FAULT = 1'b0;
    model_clear();
  endtask

  task automatic wait_period(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2100; n++) begin
      wait_cycles(1);
      if (vif.PERIOD_START) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (vif.PWM_OUT !== 1'b0) $display("FAIL reset_pwm got %b want 0", vif.PWM_OUT); else n_pass++;
    n_checks++; if (vif.DUTY !== 10'd0) $display("FAIL reset_duty got %0d want 0", vif.DUTY); else n_pass++;
    n_checks++; if (vif.DUTY_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", vif.DUTY_VALID); else n_pass++;
    n_checks++; if (vif.PERIOD_START !== 1'b0) $display("FAIL reset_pstart got %b want 0", vif.PERIOD_START); else n_pass++;
    n_checks++; if (vif.FAULT !== 1'b0) $display("FAIL reset_fault got %b want 0", vif.FAULT); else n_pass++;
    n_checks++; if (vif.OVERRUN !== 1'b0) $display("FAIL reset_overrun got %b want 0", vif.OVERRUN); else n_pass++;
  endtask

  task automatic test_pi_latency();
    logic v3, v4, f; logic [9:0] d; int exp;
    apply_reset();
    exp = model_sample(4000, 2048, 2048);
    do_sample(4000, 2048, 2048, v3, v4, d, f);
    n_checks++; if (v3 !== 1'b0) $display("FAIL pi_valid_early got %b want 0", v3); else n_pass++;
    n_checks++; if (v4 !== 1'b1) $display("FAIL pi_valid_k4 got %b want 1", v4); else n_pass++;
    n_checks++; if (d !== 10'd25) $display("FAIL pi_first_duty got %0d want 25 (model %0d)", d, exp); else n_pass++;
    n_checks++; if (vif.DUTY_VALID !== 1'b0) $display("FAIL pi_valid_width got %b want 0", vif.DUTY_VALID); else n_pass++;
    exp = model_sample(4000, 2048, 2048);
    do_sample(4000, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd27) $display("FAIL pi_second_duty got %0d want 27 (model %0d)", d, exp); else n_pass++;
  endtask

  task automatic test_windup();
    logic v3, v4, f; logic [9:0] d; int exp, bad, highs; bit ok;
    apply_reset();
    bad = 0;
    for (int n = 0; n < 21; n++) begin
      exp = model_sample(0, 2048, 2048);
      do_sample(0, 2048, 2048, v3, v4, d, f);
      if (d !== 10'(exp) || v4 !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL windup_series got %0d bad samples want 0", bad); else n_pass++;
    n_checks++; if (d !== 10'd900) $display("FAIL windup_sat got %0d want 900", d); else n_pass++;
    exp = model_sample(4096, 2048, 2048);
    do_sample(4096, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd900) $display("FAIL windup_zero_err got %0d want 900 (model %0d)", d, exp); else n_pass++;
    exp = model_sample(8191, 2048, 2048);
    do_sample(8191, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'(exp)) $display("FAIL windup_recover got %0d want %0d", d, exp); else n_pass++;
    apply_reset();
    exp = model_sample(8191, 2048, 2048);
    do_sample(8191, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd0) $display("FAIL neg_err_duty got %0d want 0", d); else n_pass++;
    wait_period(ok);
    highs = 0;
    for (int j = 0; j < 1100; j++) begin
      wait_cycles(1);
      if (vif.PWM_OUT) highs++;
    end
    n_checks++; if (!ok || highs != 0) $display("FAIL zero_duty_gate got %0d highs (wrap %0d) want 0", highs, ok); else n_pass++;
  endtask

  task automatic test_pwm();
    logic v3, v4, f; logic [9:0] d; int exp, highs, early; bit ok; logic ps_end;
    apply_reset();
    exp = model_sample(3152, 2048, 2048);
    do_sample(3152, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd250) $display("FAIL pwm_duty got %0d want 250 (model %0d)", d, exp); else n_pass++;
    wait_period(ok);
    n_checks++; if (!ok) $display("FAIL pwm_wrap_timeout got none want PERIOD_START"); else n_pass++;
    highs = 0; early = 0; ps_end = 1'b0;
    for (int j = 1; j <= 1000; j++) begin
      wait_cycles(1);
      if (vif.PWM_OUT) highs++;
      if (vif.PERIOD_START && j < 1000) early++;
      if (j == 1000) ps_end = vif.PERIOD_START;
    end
    n_checks++; if (highs != 250) $display("FAIL pwm_high_count got %0d want 250", highs); else n_pass++;
    n_checks++; if (early != 0 || ps_end !== 1'b1) $display("FAIL pwm_period got early=%0d end=%b want 0/1", early, ps_end); else n_pass++;
  endtask

  // Expects duty_act=250 from test_pwm so the gate is high when the fault hits.
  task automatic test_fault();
    logic v3, v4, f; logic [9:0] d; int exp, highs; bit ok;
    wait_period(ok);
    wait_cycles(3);
    exp = model_sample(3152, 3900, 2048);
    send(3152, 3900, 2048);
    wait_cycles(1);
    n_checks++; if (vif.FAULT !== 1'b0) $display("FAIL fault_k1 got %b want 0", vif.FAULT); else n_pass++;
    wait_cycles(1);
    n_checks++; if (vif.FAULT !== 1'b1) $display("FAIL fault_k2 got %b want 1", vif.FAULT); else n_pass++;
    n_checks++; if (vif.PWM_OUT !== 1'b1) $display("FAIL fault_gate_k2 got %b want 1", vif.PWM_OUT); else n_pass++;
    wait_cycles(1);
    n_checks++; if (vif.PWM_OUT !== 1'b0) $display("FAIL fault_gate_k3 got %b want 0", vif.PWM_OUT); else n_pass++;
    wait_cycles(1);
    n_checks++; if (vif.DUTY_VALID !== 1'b1 || vif.DUTY !== 10'(exp)) $display("FAIL fault_duty got %0d/%b want %0d/1", vif.DUTY, vif.DUTY_VALID, exp); else n_pass++;
    highs = 0;
    for (int j = 0; j < 1100; j++) begin
      wait_cycles(1);
      if (vif.PWM_OUT) highs++;
    end
    n_checks++; if (!ok || highs != 0) $display("FAIL fault_gate_low got %0d highs want 0", highs); else n_pass++;
    pulse_clear();
    n_checks++; if (vif.FAULT !== 1'b1) $display("FAIL fault_clr_ignored got %b want 1", vif.FAULT); else n_pass++;
    exp = model_sample(3152, 2000, 2048);
    do_sample(3152, 2000, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd0 || f !== 1'b1) $display("FAIL fault_held got %0d/%b want 0/1 (model %0d)", d, f, exp); else n_pass++;
    pulse_clear();
    n_checks++; if (vif.FAULT !== 1'b0) $display("FAIL fault_clr_ok got %b want 0", vif.FAULT); else n_pass++;
    exp = model_sample(3152, 2000, 2048);
    do_sample(3152, 2000, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'd250) $display("FAIL fault_integ_zero got %0d want 250 (model %0d)", d, exp); else n_pass++;
    exp = model_sample(3152, 2000, 3600);
    do_sample(3152, 2000, 3600, v3, v4, d, f);
    n_checks++; if (f !== 1'b1 || d !== 10'(exp)) $display("FAIL temp_fault got %0d/%b want %0d/1", d, f, exp); else n_pass++;
    pulse_clear();
    n_checks++; if (vif.FAULT !== 1'b1) $display("FAIL temp_clr_ignored got %b want 1", vif.FAULT); else n_pass++;
    exp = model_sample(4096, 3800, 3500);
    do_sample(4096, 3800, 3500, v3, v4, d, f);
    pulse_clear();
    n_checks++; if (vif.FAULT !== 1'b0) $display("FAIL limit_equal_clr got %b want 0", vif.FAULT); else n_pass++;
    exp = model_sample(4096, 3800, 3500);
    do_sample(4096, 3800, 3500, v3, v4, d, f);
    n_checks++; if (f !== 1'b0 || d !== 10'(exp)) $display("FAIL limit_equal got %0d/%b want %0d/0", d, f, exp); else n_pass++;
  endtask

  task automatic test_random();
    logic v3, v4, f; logic [9:0] d; int exp, v, i, t, bad;
    apply_reset();
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(3500, 4700));
      i = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3801, 8191)) : int'($urandom_range(0, 3800));
      t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3501, 8191)) : int'($urandom_range(0, 3500));
      exp = model_sample(v, i, t);
      do_sample(v, i, t, v3, v4, d, f);
      if (v3 !== 1'b0 || v4 !== 1'b1 || d !== 10'(exp) || f !== 1'(m_fault)) begin
        bad++;
        if (bad < 4) $display("FAIL rand_sample v=%0d i=%0d t=%0d got %0d/%b want %0d/%0d", v, i, t, d, f, exp, m_fault);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clear();
        if (vif.FAULT !== 1'(m_fault)) begin
          bad++;
          if (bad < 4) $display("FAIL rand_clear got %b want %0d", vif.FAULT, m_fault);
        end
      end
    end
    n_checks++; if (bad != 0) $display("FAIL rand_total got %0d bad want 0", bad); else n_pass++;
  endtask

  task automatic test_overrun();
    int exp, extra;
    apply_reset();
    exp = model_sample(4000, 2048, 2048);
    send(4000, 2048, 2048);
    wait_cycles(1);
    send(0, 2048, 2048);
    n_checks++; if (vif.OVERRUN !== 1'b1) $display("FAIL ovr_set got %b want 1", vif.OVERRUN); else n_pass++;
    wait_cycles(2);
    n_checks++; if (vif.DUTY_VALID !== 1'b1 || vif.DUTY !== 10'(exp)) $display("FAIL ovr_first_only got %0d/%b want %0d/1", vif.DUTY, vif.DUTY_VALID, exp); else n_pass++;
    extra = 0;
    for (int j = 0; j < 8; j++) begin
      wait_cycles(1);
      if (vif.DUTY_VALID) extra++;
    end
    n_checks++; if (extra != 0 || vif.OVERRUN !== 1'b1) $display("FAIL ovr_dropped got %0d extra, ovr %b want 0,1", extra, vif.OVERRUN); else n_pass++;
    apply_reset();
    send(4000, 2048, 2048);
    wait_cycles(3);
    n_checks++; if (vif.OVERRUN !== 1'b0) $display("FAIL ovr_pre_load got %b want 0", vif.OVERRUN); else n_pass++;
    send(4000, 2048, 2048);
    n_checks++; if (vif.OVERRUN !== 1'b1 || vif.DUTY_VALID !== 1'b1) $display("FAIL ovr_load_cycle got %b/%b want 1/1", vif.OVERRUN, vif.DUTY_VALID); else n_pass++;
    apply_reset();
    exp = model_sample(4000, 2048, 2048);
    exp = model_sample(4000, 2048, 2048);
    send(4000, 2048, 2048);
    wait_cycles(4);
    send(4000, 2048, 2048);
    n_checks++; if (vif.OVERRUN !== 1'b0) $display("FAIL b2b_accept got %b want 0", vif.OVERRUN); else n_pass++;
    wait_cycles(4);
    n_checks++; if (vif.DUTY_VALID !== 1'b1 || vif.DUTY !== 10'(exp)) $display("FAIL b2b_duty got %0d/%b want %0d/1", vif.DUTY, vif.DUTY_VALID, exp); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic v3, v4, f; logic [9:0] d; int exp; bit ok;
    apply_reset();
    exp = model_sample(3152, 2048, 2048);
    do_sample(3152, 2048, 2048, v3, v4, d, f);
    wait_period(ok);
    wait_cycles(5);
    n_checks++; if (!ok || vif.PWM_OUT !== 1'b1) $display("FAIL arst_pre_gate got %b want 1", vif.PWM_OUT); else n_pass++;
    send(3000, 3900, 2048);
    wait_cycles(2);
    #5 RSTn = 1'b0;
    #1;
    n_checks++; if (vif.PWM_OUT !== 1'b0 || vif.FAULT !== 1'b0) $display("FAIL arst_gate got %b/%b want 0/0", vif.PWM_OUT, vif.FAULT); else n_pass++;
    n_checks++; if (vif.DUTY !== 10'd0 || vif.DUTY_VALID !== 1'b0 || vif.PERIOD_START !== 1'b0 || vif.OVERRUN !== 1'b0)
      $display("FAIL arst_outputs got duty=%0d val=%b ps=%b ovr=%b want 0", vif.DUTY, vif.DUTY_VALID, vif.PERIOD_START, vif.OVERRUN); else n_pass++;
    wait_cycles(2);
    RSTn = 1'b1;
    wait_cycles(2);
    model_reset();
    exp = model_sample(4000, 2048, 2048);
    do_sample(4000, 2048, 2048, v3, v4, d, f);
    n_checks++; if (d !== 10'(exp) || f !== 1'b0) $display("FAIL arst_discard got %0d/%b want %0d/0", d, f, exp); else n_pass++;
  endtask

  initial begin
    vif.Vout = '0; vif.Iout = '0; vif.Temp = '0;
    vif.SAMPLE_STB = 1'b0; vif.CLR_FAULT = 1'b0;
    model_reset();
    #10;
    test_reset();
    test_pi_latency();
    test_windup();
    test_pwm();
    test_fault();
    test_random();
    test_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
